// File: rtl/child_rr_arbiter_if.sv
// rtl/child_rr_arbiter_if.sv - request/grant bundle between child instances and the arbiter
interface child_rr_arbiter_if #(
  parameter int NUM_REQ = 5
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic               busy;
  logic               timeout_err;

  modport master (output req, done, input gnt, gnt_id, busy, timeout_err);
  modport slave  (input req, done, output gnt, gnt_id, busy, timeout_err);
endinterface

// File: rtl/child_rr_arbiter.sv
// rtl/child_rr_arbiter.sv - round-robin arbiter granting one child at a time
// Optional grant watchdog built when ARB_TIMEOUT_EN is defined.
module child_rr_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  child_rr_arbiter_if.slave  bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
    $error("child_rr_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [IDW-1:0]     r_gnt_id, w_gnt_id_nxt;
  logic [IDW-1:0]     r_ptr, w_ptr_nxt;
  logic               r_armed;
  logic               w_found;
  logic [IDW-1:0]     w_winner;
  logic               w_release;
  logic               w_timeout;

  function automatic logic [IDW-1:0] wrap_idx(input int v);
    return (v >= NUM_REQ) ? IDW'(v - NUM_REQ) : IDW'(v);
  endfunction

  // Search upward from ptr+1 so the last owner ends up with lowest priority.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!w_found && bus.req[wrap_idx(int'(r_ptr) + off)]) begin
        w_found  = 1'b1;
        w_winner = wrap_idx(int'(r_ptr) + off);
      end
    end
  end

  assign w_release = bus.done[r_gnt_id] | ~bus.req[r_gnt_id];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold_cnt;
  logic       r_timeout_err;

  // done/abandon win over the watchdog, so a coinciding release raises no error.
  assign w_timeout = (r_state == GRANT) && !w_release && (r_hold_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (r_state == IDLE) r_hold_cnt <= '0;
      else                 r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  assign w_timeout       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_ptr_nxt    = r_ptr;
    case (r_state)
      IDLE: begin
        if (r_armed && w_found) begin
          w_state_nxt           = GRANT;
          w_gnt_nxt             = '0;
          w_gnt_nxt[w_winner]   = 1'b1;
          w_gnt_id_nxt          = w_winner;
        end
      end
      GRANT: begin
        if (w_release || w_timeout) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_gnt_id;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // r_armed holds off arbitration for the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_ptr    <= IDW'(NUM_REQ - 1);
      r_armed  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_ptr    <= w_ptr_nxt;
      r_armed  <= 1'b1;
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.gnt_id = r_gnt_id;
  assign bus.busy   = (r_state == GRANT);
endmodule
